// File: rtl/sync_pulse_filter.sv
// rtl/sync_pulse_filter.sv - synchronising inertial glitch filter with edge strobes
//
// Synchronises an asynchronous level, then only passes a new level once it
// has been seen for FILTER_CYCLES consecutive synchronised samples while en=1.
// Shorter excursions are dropped and, when GLITCH_COUNT_EN is defined,
// counted in a saturating glitch counter.
//
// Optional feature macro: GLITCH_COUNT_EN (adds the glitch_cnt port and logic)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   a_in       asynchronous raw input level
//   en         qualification enable
//   y_out      filtered, synchronised level
//   rise       one-cycle strobe on y_out 0->1
//   fall       one-cycle strobe on y_out 1->0
//   busy       high while a transition is being qualified
//   glitch_cnt saturating count of rejected transitions (GLITCH_COUNT_EN only)
module sync_pulse_filter #(
  parameter int FILTER_CYCLES = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             en,
  output logic             y_out,
  output logic             rise,
  output logic             fall,
`ifdef GLITCH_COUNT_EN
  output logic [CNT_W-1:0] glitch_cnt,
`endif
  output logic             busy
);

  localparam logic [7:0] FC = 8'(FILTER_CYCLES);

  typedef enum logic [1:0] {
    STABLE_LO,
    QUAL_HI,
    STABLE_HI,
    QUAL_LO
  } state_t;

  state_t                 state, state_n;
  logic [7:0]             cnt, cnt_n, cnt_inc;
  logic                   y_n, rise_n, fall_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   a_s;

  assign a_s     = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt + 8'd1;
  assign busy    = (state == QUAL_HI) || (state == QUAL_LO);

  // Synchroniser runs independently of en so a_s is always current.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LO;
      cnt   <= 8'd0;
      y_out <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      y_out <= y_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    y_n     = y_out;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (en && a_s) begin
          if (FC == 8'd1) begin
            // A one-sample filter accepts the new level immediately.
            state_n = STABLE_HI;
            y_n     = 1'b1;
            rise_n  = 1'b1;
            cnt_n   = 8'd0;
          end else begin
            state_n = QUAL_HI;
            cnt_n   = 8'd1;
          end
        end
      end
      QUAL_HI: begin
        if (!en) begin
          state_n = STABLE_LO;
          cnt_n   = 8'd0;
        end else if (a_s) begin
          if (cnt_inc == FC) begin
            state_n = STABLE_HI;
            y_n     = 1'b1;
            rise_n  = 1'b1;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt_inc;
          end
        end else begin
          state_n = STABLE_LO;
          cnt_n   = 8'd0;
        end
      end
      STABLE_HI: begin
        if (en && !a_s) begin
          if (FC == 8'd1) begin
            state_n = STABLE_LO;
            y_n     = 1'b0;
            fall_n  = 1'b1;
            cnt_n   = 8'd0;
          end else begin
            state_n = QUAL_LO;
            cnt_n   = 8'd1;
          end
        end
      end
      QUAL_LO: begin
        if (!en) begin
          state_n = STABLE_HI;
          cnt_n   = 8'd0;
        end else if (!a_s) begin
          if (cnt_inc == FC) begin
            state_n = STABLE_LO;
            y_n     = 1'b0;
            fall_n  = 1'b1;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt_inc;
          end
        end else begin
          state_n = STABLE_HI;
          cnt_n   = 8'd0;
        end
      end
      default: begin
        state_n = STABLE_LO;
        cnt_n   = 8'd0;
      end
    endcase
  end

`ifdef GLITCH_COUNT_EN
  // A glitch is a qualification that falls back because a_s reverted;
  // an en=0 abort is deliberately not counted.
  logic glitch_inc;

  assign glitch_inc = en && (((state == QUAL_HI) && !a_s) ||
                             ((state == QUAL_LO) &&  a_s));

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_inc && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_pulse_filter.sv
// tb/tb_sync_pulse_filter.sv - self-checking bench for sync_pulse_filter
module tb_sync_pulse_filter;

  localparam int FC   = 4;
  localparam int SS   = 2;
  localparam int CW   = 2;
  localparam int GMAX = (1 << CW) - 1;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic a_in = 1'b0;
  logic en   = 1'b1;
  logic y_out, rise, fall, busy;
`ifdef GLITCH_COUNT_EN
  logic [CW-1:0] glitch_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sync_pulse_filter #(
    .FILTER_CYCLES(FC),
    .SYNC_STAGES  (SS),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .en        (en),
    .y_out     (y_out),
    .rise      (rise),
    .fall      (fall),
`ifdef GLITCH_COUNT_EN
    .glitch_cnt(glitch_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a_in is delayed SS samples, then y flips once FC
  // consecutive enabled samples disagree with it.
  bit mq[$];
  int run     = 0;
  bit my      = 0;
  bit mrise   = 0;
  bit mfall   = 0;
  int mglitch = 0;

  task automatic model_step();
    bit s;
    if (rst) begin
      mq = {};
      for (int i = 0; i < SS; i++) mq.push_back(1'b0);
      run = 0; my = 0; mrise = 0; mfall = 0; mglitch = 0;
    end else begin
      s = mq[SS-1];
      mq.push_front(a_in);
      void'(mq.pop_back());
      mrise = 0;
      mfall = 0;
      if (!en) begin
        run = 0;
      end else if (s != my) begin
        run++;
        if (run == FC) begin
          my = s; mrise = s; mfall = !s; run = 0;
        end
      end else begin
        if (run > 0 && mglitch < GMAX) mglitch++;
        run = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("m_y_out", y_out, my);
      check("m_rise", rise, mrise);
      check("m_fall", fall, mfall);
      check("m_busy", busy, run > 0);
`ifdef GLITCH_COUNT_EN
      check("m_glitch", glitch_cnt, mglitch);
`endif
    end
  end

  // Holds a_in at v for n edges, reporting strobe positions and busy cycles.
  task automatic hold(input bit v, input int n, output int first_rise,
                      output int n_rise, output int first_fall,
                      output int n_fall, output int n_busy);
    first_rise = 0; n_rise = 0; first_fall = 0; n_fall = 0; n_busy = 0;
    a_in = v;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (rise) begin n_rise++; if (first_rise == 0) first_rise = i; end
      if (fall) begin n_fall++; if (first_fall == 0) first_fall = i; end
      if (busy) n_busy++;
    end
  endtask

  int fr, nr, ff, nf, nb, fr2, nr2, ff2, nf2, nb2, rlen;
`ifdef GLITCH_COUNT_EN
  int g0;
`endif

  initial begin
    @(negedge clk);
    // Reset held with a_in high
    a_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_y", y_out, 0);
      check("rst_busy", busy, 0);
      check("rst_strobe", rise | fall, 0);
    end
    rst = 1'b0;
    hold(1, 8, fr, nr, ff, nf, nb);
    check("t1_rise_edge", fr, 6);
    check("t1_rise_cnt", nr, 1);
    check("t1_busy_cycles", nb, 3);
    check("t1_y", y_out, 1);
    hold(0, 10, fr, nr, ff, nf, nb);
    check("t1_fall_edge", ff, 6);
    check("t1_fall_cnt", nf, 1);

    // Long levels
    hold(1, 10, fr, nr, ff, nf, nb);
    check("t2_rise_edge", fr, 6);
    check("t2_rise_cnt", nr, 1);
    hold(0, 10, fr, nr, ff, nf, nb);
    check("t2_fall_edge", ff, 6);
    check("t2_fall_cnt", nf, 1);
    check("t2_y", y_out, 0);

    // 4-cycle pulse accepted, 3-cycle pulse rejected
    hold(1, 4, fr, nr, ff, nf, nb);
    hold(0, 12, fr2, nr2, ff2, nf2, nb2);
    check("t3_4cyc_rise", nr + nr2, 1);
    check("t3_4cyc_fall", nf2, 1);
`ifdef GLITCH_COUNT_EN
    g0 = glitch_cnt;
`endif
    hold(1, 3, fr, nr, ff, nf, nb);
    hold(0, 10, fr2, nr2, ff2, nf2, nb2);
    check("t3_3cyc_rise", nr + nr2, 0);
    check("t3_3cyc_busy", nb + nb2, 3);
    check("t3_3cyc_y", y_out, 0);
`ifdef GLITCH_COUNT_EN
    check("t3_glitch_inc", glitch_cnt, (g0 < GMAX) ? g0 + 1 : GMAX);
`endif

    // Sub-cycle pulse between edges is never sampled
    @(posedge clk);
    #3 a_in = 1'b1;
    #2 a_in = 1'b0;
    hold(0, 8, fr, nr, ff, nf, nb);
    check("t4_busy", nb, 0);
    check("t4_rise", nr, 0);
    check("t4_y", y_out, 0);

    // en drop at cnt=2 aborts without glitch, then rst mid-qualification
`ifdef GLITCH_COUNT_EN
    g0 = glitch_cnt;
`endif
    hold(1, 4, fr, nr, ff, nf, nb);
    check("t5_busy_before", busy, 1);
    en = 1'b0;
    @(negedge clk);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_y", y_out, 0);
    check("t5_abort_rise", rise, 0);
`ifdef GLITCH_COUNT_EN
    check("t5_abort_glitch", glitch_cnt, g0);
`endif
    en = 1'b1;
    hold(1, 2, fr, nr, ff, nf, nb);
    check("t5_requal_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_y", y_out, 0);
    check("t5_rst_strobe", rise | fall, 0);
`ifdef GLITCH_COUNT_EN
    check("t5_rst_glitch", glitch_cnt, 0);
`endif
    a_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Five 2-cycle pulses: glitch counter saturates
    for (int k = 1; k <= 5; k++) begin
      hold(1, 2, fr, nr, ff, nf, nb);
      hold(0, 6, fr2, nr2, ff2, nf2, nb2);
      check("t6_no_rise", nr + nr2, 0);
`ifdef GLITCH_COUNT_EN
      check("t6_glitch_sat", glitch_cnt, (k < 3) ? k : 3);
`endif
    end

    // Randomised levels, enable drops and occasional resets
    rlen = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rlen == 0) begin
        a_in = 1'($urandom_range(0, 1));
        rlen = $urandom_range(1, 8);
      end
      rlen--;
      en  = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
